// File: rtl/char_buffer_arbiter.sv
// char_buffer_arbiter
//   Owns the single-port character RAM behind the COLS x ROWS text grid and
//   shares it, one access per cycle, between three requesters:
//     display fetch (highest), clear-screen sequencer, message writer (lowest).
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   disp_req           fetch request for cell (disp_char_x, disp_char_y)
//   disp_data/valid    fetched code, valid exactly 3 cycles after disp_req
//   wr_req             writer request, held with wr_x/wr_y/wr_data until wr_ack
//   wr_ack / wr_err    one-cycle acknowledge; wr_err marks an off-grid cell
//   clr_start          start filling the whole grid with BLANK_CHAR
//   clr_busy           clear sequence in progress
//   ram_addr/we/wdata  registered RAM command bus
//   ram_rdata          RAM read data, one cycle after ram_addr
module char_buffer_arbiter #(
  parameter int                COLS       = 50,
  parameter int                ROWS       = 40,
  parameter int                ADDR_W     = 11,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [5:0]        disp_char_x,
  input  logic [5:0]        disp_char_y,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_req,
  input  logic [5:0]        wr_x,
  input  logic [5:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int                CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              grant_clr, grant_wr;

  logic              disp_in_range, wr_in_range;
  logic [ADDR_W-1:0] disp_addr, wr_addr;

  // Display pipeline control: p0 = RAM address on the bus, p1 = RAM data back.
  logic              vld_p0, vld_p1;
  logic              oor_p0, oor_p1;

  function automatic logic cell_in_range(input logic [5:0] x, input logic [5:0] y);
    return (int'(x) < COLS) && (int'(y) < ROWS);
  endfunction

  // Row-major cell address; only meaningful when cell_in_range() holds.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
    return ADDR_W'(int'(y) * COLS + int'(x));
  endfunction

  assign disp_in_range = cell_in_range(disp_char_x, disp_char_y);
  assign disp_addr     = cell_addr(disp_char_x, disp_char_y);
  assign wr_in_range   = cell_in_range(wr_x, wr_y);
  assign wr_addr       = cell_addr(wr_x, wr_y);

  assign clr_busy = (state == S_CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Arbitration and clear sequencing. The writer is refused while wr_ack is
  // high so a still-held request is not granted twice, and refused when
  // clr_start is high so a clear always goes first.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    grant_clr   = 1'b0;
    grant_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_start) begin
          state_nxt = S_CLEAR;
        end else if (wr_req && !disp_req && !wr_ack) begin
          grant_wr = 1'b1;
        end
      end
      S_CLEAR: begin
        if (!disp_req) begin
          grant_clr = 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state_nxt   = S_IDLE;
            clr_cnt_nxt = '0;
          end else begin
            clr_cnt_nxt = clr_cnt + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      vld_p0     <= 1'b0;
      oor_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      oor_p1     <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      // Stage p0: drive the RAM command for the winner of this cycle.
      ram_we <= 1'b0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      vld_p0 <= disp_req;
      oor_p0 <= disp_req && !disp_in_range;
      if (disp_req) begin
        // Off-grid fetches leave the bus untouched; the blank is substituted at p2.
        if (disp_in_range) begin
          ram_addr <= disp_addr;
        end
      end else if (grant_clr) begin
        ram_addr  <= clr_cnt;
        ram_we    <= 1'b1;
        ram_wdata <= BLANK_CHAR;
      end else if (grant_wr) begin
        wr_ack <= 1'b1;
        wr_err <= !wr_in_range;
        if (wr_in_range) begin
          ram_addr  <= wr_addr;
          ram_we    <= 1'b1;
          ram_wdata <= wr_data;
        end
      end

      // Stage p1: RAM is returning data for the p0 address.
      vld_p1 <= vld_p0;
      oor_p1 <= oor_p0;

      // Stage p2: register the fetched code.
      disp_valid <= vld_p1;
      if (vld_p1) begin
        disp_data <= oor_p1 ? BLANK_CHAR : ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_char_buffer_arbiter.sv
module tb_char_buffer_arbiter;

  localparam int         COLS  = 50;
  localparam int         ROWS  = 40;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_req = 1'b0;
  logic [5:0]  disp_char_x = '0, disp_char_y = '0;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        wr_req = 1'b0;
  logic [5:0]  wr_x = '0, wr_y = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack, wr_err;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [CELLS];
  logic [7:0] mem [2048];
  bit   [2047:0] touched;

  always #5 clk = ~clk;

  char_buffer_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_char_x(disp_char_x), .disp_char_y(disp_char_y),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Power-up RAM contents, a fixed scramble of the address.
  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 73 + 19) ^ (a >> 3));
  endfunction

  function automatic bit on_grid(input int x, input int y);
    return (x < COLS) && (y < ROWS);
  endfunction

  // Single-port RAM with one-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      touched[ram_addr] <= 1'b1;
    end
    ram_rdata <= touched[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold a write request until acknowledged; report what the bus showed.
  task automatic wr_txn(input int x, input int y, input logic [7:0] d,
                        output int k, output logic we, output logic err,
                        output logic [10:0] addr, output logic [7:0] wd);
    wr_x = 6'(x); wr_y = 6'(y); wr_data = d; wr_req = 1'b1;
    k = -1; we = 1'b0; err = 1'b0; addr = '0; wd = '0;
    for (int c = 0; c < 3000 && k < 0; c++) begin
      @(negedge clk);
      if (wr_ack) begin
        k = c; we = ram_we; err = wr_err; addr = ram_addr; wd = ram_wdata;
      end
      next_cycle();
    end
    wr_req = 1'b0;
  endtask

  // One-cycle fetch; returns bus state one cycle later and the valid latency.
  task automatic disp_txn(input int x, input int y, output logic [10:0] addr1,
                          output logic we1, output int lat, output logic [7:0] data);
    disp_char_x = 6'(x); disp_char_y = 6'(y); disp_req = 1'b1;
    lat = -1; data = '0; addr1 = '0; we1 = 1'b0;
    @(negedge clk);
    next_cycle();
    disp_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin addr1 = ram_addr; we1 = ram_we; end
      if (disp_valid && lat < 0) begin lat = c; data = disp_data; end
      next_cycle();
    end
  endtask

  // Start a clear and watch the bus until the pending write is acknowledged.
  task automatic run_clear(input int stall_at, input int stall_len, input int restart_at,
                           input int wr_at, input int wx, input int wy, input logic [7:0] wd,
                           output int busy_cnt, output int clr_writes, output int ack_c,
                           output bit order_ok, output bit ack_ok);
    int last_busy;
    busy_cnt = 0; clr_writes = 0; ack_c = -1; order_ok = 1'b1; ack_ok = 1'b0; last_busy = -1;
    for (int c = 0; c < 2600 && ack_c < 0; c++) begin
      clr_start = (c == 0) || (c == restart_at);
      disp_req  = (c >= stall_at) && (c < stall_at + stall_len);
      if (c == wr_at) begin
        wr_x = 6'(wx); wr_y = 6'(wy); wr_data = wd; wr_req = 1'b1;
      end
      @(negedge clk);
      if (clr_busy) begin busy_cnt++; last_busy = c; end
      if (ram_we && !wr_ack) begin
        if (ram_addr !== 11'(clr_writes) || ram_wdata !== BLANK) order_ok = 1'b0;
        clr_writes++;
      end
      if (wr_ack) begin
        ack_c  = c;
        ack_ok = ram_we && (ram_addr == 11'(wy * COLS + wx)) && (ram_wdata == wd)
                 && !wr_err && !clr_busy && (last_busy < c);
      end
      next_cycle();
    end
    clr_start = 1'b0; disp_req = 1'b0; wr_req = 1'b0;
    repeat (4) next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ram_addr, ram_wdata, disp_data, ram_we, wr_ack, wr_err, disp_valid, clr_busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: addr=%0d wdata=%h ddata=%h we=%b ack=%b err=%b dv=%b busy=%b, all required 0",
               ram_addr, ram_wdata, disp_data, ram_we, wr_ack, wr_err, disp_valid, clr_busy);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_basic();
    int k; logic we, err; logic [10:0] a; logic [7:0] wd;
    wr_txn(3, 2, 8'h41, k, we, err, a, wd);
    n_cmp++;
    if (k !== 1) begin n_bad++; $display("FAIL write_latency: ack at %0d, required 1", k); end
    n_cmp++;
    if ({we, err, a, wd} !== {1'b1, 1'b0, 11'd103, 8'h41}) begin
      n_bad++;
      $display("FAIL write_bus: we=%b err=%b addr=%0d data=%h, required we=1 err=0 addr=103 data=41", we, err, a, wd);
    end
    @(negedge clk);
    n_cmp++;
    if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL write_ack_pulse: wr_ack=%b one cycle later, required 0", wr_ack); end
    next_cycle();
    ref_mem[103] = 8'h41;
  endtask

  task automatic test_readback();
    logic [10:0] a; logic we; int lat; logic [7:0] d;
    disp_txn(3, 2, a, we, lat, d);
    n_cmp++;
    if ({lat == 3, a, we, d} !== {1'b1, 11'd103, 1'b0, 8'h41}) begin
      n_bad++;
      $display("FAIL readback_3_2: lat=%0d addr=%0d we=%b data=%h, required lat=3 addr=103 we=0 data=41", lat, a, we, d);
    end
    disp_txn(49, 39, a, we, lat, d);
    n_cmp++;
    if ({lat == 3, a, we, d} !== {1'b1, 11'd1999, 1'b0, ref_mem[1999]}) begin
      n_bad++;
      $display("FAIL readback_corner: lat=%0d addr=%0d we=%b data=%h, required lat=3 addr=1999 we=0 data=%h",
               lat, a, we, d, ref_mem[1999]);
    end
  endtask

  task automatic test_random_rw();
    int k; logic we, err; logic [10:0] a; logic [7:0] wd;
    int qx[$], qy[$];
    int bx[16], by[16];
    logic [7:0] exp_d[16];
    for (int i = 0; i < 24; i++) begin
      int x, y; logic [7:0] d; bit ok;
      x = int'($urandom_range(0, 55)); y = int'($urandom_range(0, 43)); d = 8'($urandom);
      ok = on_grid(x, y);
      wr_txn(x, y, d, k, we, err, a, wd);
      n_cmp++;
      if (k !== 1 || we !== ok || err !== !ok || (ok && (a !== 11'(y * COLS + x) || wd !== d))) begin
        n_bad++;
        $display("FAIL rand_write(%0d,%0d): ack_at=%0d we=%b err=%b addr=%0d data=%h, required ack_at=1 we=%b err=%b addr=%0d data=%h",
                 x, y, k, we, err, a, wd, ok, !ok, y * COLS + x, d);
      end
      if (ok) begin ref_mem[y * COLS + x] = d; qx.push_back(x); qy.push_back(y); end
    end
    for (int i = 0; i < 16; i++) begin
      if (qx.size() > 0 && i % 2 == 0) begin
        int j; j = int'($urandom_range(0, qx.size() - 1));
        bx[i] = qx[j]; by[i] = qy[j];
      end else begin
        bx[i] = int'($urandom_range(0, 52)); by[i] = int'($urandom_range(0, 42));
      end
      exp_d[i] = on_grid(bx[i], by[i]) ? ref_mem[by[i] * COLS + bx[i]] : BLANK;
    end
    for (int c = 0; c < 20; c++) begin
      bit exp_v;
      if (c < 16) begin
        disp_req = 1'b1; disp_char_x = 6'(bx[c]); disp_char_y = 6'(by[c]);
      end else begin
        disp_req = 1'b0;
      end
      @(negedge clk);
      if (c >= 1 && c <= 16 && on_grid(bx[c-1], by[c-1])) begin
        n_cmp++;
        if (ram_addr !== 11'(by[c-1] * COLS + bx[c-1]) || ram_we !== 1'b0) begin
          n_bad++;
          $display("FAIL burst_addr[%0d]: addr=%0d we=%b, required addr=%0d we=0", c - 1, ram_addr, ram_we,
                   by[c-1] * COLS + bx[c-1]);
        end
      end
      exp_v = (c >= 3) && (c <= 18);
      n_cmp++;
      if (disp_valid !== exp_v || (exp_v && disp_data !== exp_d[c-3])) begin
        n_bad++;
        $display("FAIL burst_read cycle %0d: valid=%b data=%h, required valid=%b data=%h",
                 c, disp_valid, disp_data, exp_v, exp_v ? exp_d[c-3] : 8'h00);
      end
      next_cycle();
    end
  endtask

  task automatic test_priority();
    int ack_c; logic we; logic [10:0] a; logic [7:0] wd;
    ack_c = -1; we = 1'b0; a = '0; wd = '0;
    wr_x = 6'd10; wr_y = 6'd10; wr_data = 8'h5A; wr_req = 1'b1;
    for (int c = 0; c < 15; c++) begin
      disp_req = (c < 10);
      disp_char_x = 6'($urandom_range(0, 49)); disp_char_y = 6'($urandom_range(0, 39));
      @(negedge clk);
      if (wr_ack && ack_c < 0) begin ack_c = c; we = ram_we; a = ram_addr; wd = ram_wdata; end
      next_cycle();
      if (ack_c >= 0) wr_req = 1'b0;
    end
    n_cmp++;
    if (ack_c !== 11) begin n_bad++; $display("FAIL stall_ack_cycle: ack at %0d, required 11", ack_c); end
    n_cmp++;
    if ({we, a, wd} !== {1'b1, 11'd510, 8'h5A}) begin
      n_bad++;
      $display("FAIL stall_write_bus: we=%b addr=%0d data=%h, required we=1 addr=510 data=5a", we, a, wd);
    end
    ref_mem[510] = 8'h5A;
  endtask

  task automatic test_out_of_range();
    int k, lat; logic we, err; logic [10:0] a, prev; logic [7:0] wd, d;
    wr_txn(50, 5, 8'hEE, k, we, err, a, wd);
    n_cmp++;
    if (k !== 1 || we !== 1'b0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_write_x: ack_at=%0d we=%b err=%b, required ack_at=1 we=0 err=1", k, we, err);
    end
    wr_txn(0, 40, 8'hEE, k, we, err, a, wd);
    n_cmp++;
    if (k !== 1 || we !== 1'b0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_write_y: ack_at=%0d we=%b err=%b, required ack_at=1 we=0 err=1", k, we, err);
    end
    prev = ram_addr;
    disp_txn(0, 40, a, we, lat, d);
    n_cmp++;
    if (lat !== 3 || d !== BLANK || we !== 1'b0 || a !== prev) begin
      n_bad++;
      $display("FAIL oor_read: lat=%0d data=%h we=%b addr=%0d, required lat=3 data=20 we=0 addr=%0d", lat, d, we, a, prev);
    end
  endtask

  task automatic test_clear();
    int busy, nw, ack_c; bit order_ok, ack_ok;
    logic [10:0] a; logic we; int lat; logic [7:0] d;
    run_clear(1_000_000, 0, 100, 5, 7, 7, 8'h33, busy, nw, ack_c, order_ok, ack_ok);
    for (int i = 0; i < CELLS; i++) ref_mem[i] = BLANK;
    ref_mem[7 * COLS + 7] = 8'h33;
    n_cmp++;
    if (busy !== 2000) begin n_bad++; $display("FAIL clear_busy_len: %0d cycles, required 2000", busy); end
    n_cmp++;
    if (nw !== 2000 || !order_ok) begin
      n_bad++; $display("FAIL clear_writes: count=%0d in_order=%0b, required count=2000 in_order=1", nw, order_ok);
    end
    n_cmp++;
    if (ack_c !== 2002 || !ack_ok) begin
      n_bad++; $display("FAIL clear_pending_write: ack_at=%0d bus_ok=%0b, required ack_at=2002 bus_ok=1", ack_c, ack_ok);
    end
    disp_txn(7, 7, a, we, lat, d);
    n_cmp++;
    if (lat !== 3 || d !== 8'h33) begin n_bad++; $display("FAIL clear_read_7_7: lat=%0d data=%h, required 3/33", lat, d); end
    disp_txn(49, 39, a, we, lat, d);
    n_cmp++;
    if (lat !== 3 || d !== BLANK) begin n_bad++; $display("FAIL clear_read_corner: lat=%0d data=%h, required 3/20", lat, d); end
  endtask

  task automatic test_simultaneous();
    int busy, nw, ack_c; bit order_ok, ack_ok;
    logic [10:0] a; logic we; int lat; logic [7:0] d;
    run_clear(300, 4, -1, 0, 1, 1, 8'h77, busy, nw, ack_c, order_ok, ack_ok);
    ref_mem[1 * COLS + 1] = 8'h77;
    n_cmp++;
    if (busy !== 2004 || nw !== 2000 || !order_ok) begin
      n_bad++;
      $display("FAIL simul_clear: busy=%0d writes=%0d in_order=%0b, required busy=2004 writes=2000 in_order=1", busy, nw, order_ok);
    end
    n_cmp++;
    if (ack_c !== 2006 || !ack_ok) begin
      n_bad++; $display("FAIL simul_write: ack_at=%0d bus_ok=%0b, required ack_at=2006 bus_ok=1", ack_c, ack_ok);
    end
    disp_txn(1, 1, a, we, lat, d);
    n_cmp++;
    if (lat !== 3 || d !== 8'h77) begin n_bad++; $display("FAIL simul_read: lat=%0d data=%h, required 3/77", lat, d); end
  endtask

  task automatic test_reset_mid_clear();
    bit hit; int first_addr, done_c;
    logic [10:0] a; logic we; int lat; logic [7:0] d;
    hit = 1'b0;
    for (int c = 0; c < 700 && !hit; c++) begin
      clr_start = (c == 0);
      @(negedge clk);
      if (ram_we && ram_addr == 11'd499) begin
        hit = 1'b1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({clr_busy, ram_we, wr_ack, disp_valid, ram_addr} !== '0) begin
          n_bad++;
          $display("FAIL reset_mid_clear: busy=%b we=%b ack=%b dv=%b addr=%0d, required all 0",
                   clr_busy, ram_we, wr_ack, disp_valid, ram_addr);
        end
      end
      if (!hit) next_cycle();
    end
    clr_start = 1'b0;
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL reset_mid_clear_reach: write to 499 not seen, required within 700 cycles"); end
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    first_addr = -1;
    done_c = -1;
    for (int c = 0; c < 2200 && done_c < 0; c++) begin
      clr_start = (c == 0);
      @(negedge clk);
      if (ram_we && first_addr < 0) first_addr = int'(ram_addr);
      if (c > 1 && !clr_busy) done_c = c;
      next_cycle();
    end
    clr_start = 1'b0;
    for (int i = 0; i < CELLS; i++) ref_mem[i] = BLANK;
    n_cmp++;
    if (first_addr !== 0) begin n_bad++; $display("FAIL restart_addr: first clear write at %0d, required 0", first_addr); end
    n_cmp++;
    if (done_c !== 2001) begin n_bad++; $display("FAIL restart_len: busy fell at %0d, required 2001", done_c); end
    for (int i = 0; i < 4; i++) begin
      int x, y;
      x = int'($urandom_range(0, 49)); y = int'($urandom_range(0, 39));
      disp_txn(x, y, a, we, lat, d);
      n_cmp++;
      if (lat !== 3 || d !== ref_mem[y * COLS + x]) begin
        n_bad++; $display("FAIL post_clear_read(%0d,%0d): lat=%0d data=%h, required 3/20", x, y, lat, d);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < CELLS; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_write_basic();
    test_readback();
    test_random_rw();
    test_priority();
    test_out_of_range();
    test_clear();
    test_simultaneous();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/char_buffer_arbiter.md
Name: char_buffer_arbiter

Overview:
- Owns the single-port character RAM behind the 50x40 text grid (10x10-pixel cells, origin at pixel x=140, y=80).
- Shares the RAM between three requesters:
  - the display fetch path, driven by grid-cell coordinates from the pixel-to-cell converter;
  - the message writer (keyboard/UART text);
  - an internal clear-screen sequencer.
- Arbitration is per cycle with fixed priority. Writer access uses a req/ack handshake.

Parameters:
- COLS, 50, grid columns
- ROWS, 40, grid rows
- ADDR_W, 11, RAM address width (must satisfy 2^ADDR_W >= COLS*ROWS)
- DATA_W, 8, character code width
- BLANK_CHAR, 8'h20, fill code written by clear and returned for out-of-range display reads

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- disp_req  in  1  display fetch request for the current cell
- disp_char_x  in  6  display cell column
- disp_char_y  in  6  display cell row
- disp_data  out  DATA_W  fetched character code
- disp_valid  out  1  disp_data valid strobe (one cycle)
- wr_req  in  1  writer request; held with wr_x/wr_y/wr_data stable until wr_ack
- wr_x  in  6  writer cell column
- wr_y  in  6  writer cell row
- wr_data  in  DATA_W  character to store
- wr_ack  out  1  one-cycle acknowledge
- wr_err  out  1  pulses with wr_ack when the coordinate was out of range
- clr_start  in  1  start clear-screen
- clr_busy  out  1  clear in progress
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous read latency

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to S_IDLE; clear counter = 0.
  - All outputs 0, except disp_data = 0.
  - RAM contents are not touched. Deassertion takes effect on the next clk edge.
- Address mapping: addr = y*COLS + x, computed in ADDR_W bits. Valid only when x<COLS and y<ROWS.
- Per-cycle priority (evaluated in cycle N, RAM access driven in N+1):
  1. disp_req
  2. clear sequencer (S_CLEAR)
  3. wr_req
- Display path:
  - disp_req sampled in N → ram_addr, ram_we=0 in N+1 → ram_rdata in N+2 → disp_data/disp_valid registered, high in N+3.
  - Fixed latency of 3 cycles. Back-to-back requests give back-to-back valids.
  - Out-of-range coordinate: no RAM read issued; disp_data=BLANK_CHAR and disp_valid still asserted at N+3.
- Writer path:
  - A write is granted in N only when wr_req=1, no disp_req, state S_IDLE, clr_start=0, and wr_ack=0 in N.
  - In N+1: ram_we=1 with addr/data; wr_ack=1 for exactly one cycle.
  - This gives at most one write per 2 cycles.
  - Out of range: no RAM write; wr_ack and wr_err both pulse in N+1.
  - A waiting request is never dropped; it is held until granted.
- FSM:
  - S_IDLE → S_CLEAR when clr_start=1 (clr_start beats a simultaneous wr_req). clr_busy=1 from the next cycle.
  - S_CLEAR: on each cycle without disp_req, write BLANK_CHAR at address = counter, then counter++. When disp_req=1, the counter holds.
  - After the write of address COLS*ROWS-1 is issued: go to S_IDLE, counter=0, clr_busy=0 in the following cycle.
  - clr_start while in S_CLEAR is ignored; the clear does not restart.
  - wr_ack is never asserted while clr_busy=1.
- Reset mid-clear: clear aborts, clr_busy=0. Partially cleared RAM is acceptable.
- Display reads during a clear return whatever the RAM holds; the clear gives no coherency guarantee.

Test Plan:
- Reset: hold rst=0 for 3 cycles → all outputs 0. Release, then wr_req with x=3, y=2, data=8'h41 → ram_addr=103, ram_we=1, wr_ack=1 exactly 1 cycle after grant.
- Readback: display request for x=3, y=2 → disp_valid 3 cycles later, disp_data=8'h41. Request for x=49, y=39 → ram_addr=1999.
- Priority/stall: disp_req held high 10 cycles alongside wr_req → no wr_ack during those cycles. wr_ack arrives 2 cycles after disp_req falls; write data unchanged.
- Out of range: wr_x=50 → wr_ack=1, wr_err=1, ram_we stays 0. disp_char_y=40 → disp_data=8'h20, disp_valid at N+3, no RAM access.
- Clear: clr_start → 2000 writes of 8'h20 covering addresses 0..1999. clr_busy high exactly 2000 cycles with no disp_req. A wr_req pending during the clear is acked after clr_busy falls. A second clr_start mid-clear is ignored.
- Simultaneous and reset cases: clr_start and wr_req in the same cycle → clear first, write after. rst=0 at counter=500 → clr_busy=0 immediately; after release, counter restarts at 0 on the next clr_start.
